mem_select_ctrl: RTL and testbench
==================================

MEM_SELECT_CTRL -- requirements
Module: mem_select_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: address width.
REQ-002 Parameter DATA_W, default 16: CPU and IRAM data width.
REQ-003 Parameter DRAM_W, default 8: DRAM data width; DRAM_W SHALL be <= DATA_W.
REQ-004 Parameter IRAM_AW, default 10: IRAM address width; IRAM region = addresses 0 .. 2^IRAM_AW-1.
REQ-005 Parameter RD_LAT, default 1, legal 1..4: memory read latency in clk1 cycles.
REQ-006 Parameter IRAM_WP, default 0: 1 = IRAM write-protected.
REQ-007 clk1  in  1  single clock; all state updates on its rising edge.
REQ-008 rst1_n  in  1  reset, synchronous, active-low.
REQ-009 req  in  1  CPU access request.
REQ-010 we  in  1  1 = write, 0 = read; qualified by req.
REQ-011 addr  in  ADDR_W  CPU address.
REQ-012 wdata  in  DATA_W  CPU write data.
REQ-013 ready  out  1  controller can accept a request this cycle.
REQ-014 rvalid  out  1  one-cycle pulse; rdata valid.
REQ-015 rdata  out  DATA_W  read data.
REQ-016 err  out  1  one-cycle pulse on a rejected write.
REQ-017 iram_we  out  1; iram_addr  out  IRAM_AW; iram_wdata  out  DATA_W; iram_rdata  in  DATA_W.
REQ-018 dram_we  out  1; dram_addr  out  ADDR_W; dram_wdata  out  DRAM_W; dram_rdata  in  DRAM_W.

Function
REQ-019 Region decode SHALL be sel_d = OR of addr[ADDR_W-1:IRAM_AW]; sel_d=0 selects IRAM, sel_d=1 selects DRAM.
REQ-020 iram_addr = addr[IRAM_AW-1:0], dram_addr = addr, iram_wdata = wdata, dram_wdata = wdata[DRAM_W-1:0]; all driven combinationally every cycle.
REQ-021 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-022 ready = 1 in IDLE only; a request is accepted when req & ready.
REQ-023 Accepted write: in the acceptance cycle, exactly one of iram_we or dram_we SHALL be driven high per sel_d; the FSM stays in IDLE; no rvalid is produced.
REQ-024 Accepted write with sel_d=0 and IRAM_WP=1: iram_we SHALL stay 0; err SHALL pulse high the following cycle.
REQ-025 iram_we and dram_we SHALL never both be high, and SHALL be 0 whenever not (req & ready & we).
REQ-026 Accepted read: the controller SHALL latch sel_d into sel_q, load lat_cnt = RD_LAT-1, and go to WAIT.
REQ-027 WAIT: lat_cnt decrements each cycle; at lat_cnt = 0 the next state is RESP.
REQ-028 RESP: rvalid = 1 for exactly one cycle; the next state is IDLE.
REQ-029 rdata in RESP SHALL be iram_rdata when sel_q=0, and dram_rdata zero-extended to DATA_W when sel_q=1; this holds sampling memory data RD_LAT cycles after acceptance.
REQ-030 rdata SHALL be registered and hold its last read value outside RESP.
REQ-031 Read-to-rvalid latency SHALL be RD_LAT+1 cycles after acceptance.
REQ-032 Back-to-back reads: a new read SHALL be acceptable in the cycle after RESP, giving a throughput of one read per RD_LAT+2 cycles.
REQ-033 req while ready = 0 SHALL be ignored with no memory strobes; the CPU holds req until accepted.
REQ-034 Address boundary: 2^IRAM_AW-1 selects IRAM; 2^IRAM_AW selects DRAM; all-ones selects DRAM.

Reset
REQ-035 While rst1_n = 0 at a clk1 edge: state = IDLE, lat_cnt = 0, sel_q = 0, rdata = 0, rvalid = 0, err = 0.
REQ-036 ready SHALL be 1 in the first cycle after reset releases.
REQ-037 Reset asserted in WAIT or RESP SHALL abort the read; no rvalid SHALL follow.
REQ-038 Memory write enables SHALL be 0 during any cycle with rst1_n = 0.

Verification
REQ-039 Defaults; write 0x1234 to 0x03FF, then read 0x03FF -> iram_we pulses once; rvalid 2 cycles after acceptance with rdata = 0x1234.
REQ-040 Write 0xABCD to 0x0400, then read 0x0400 -> dram_we pulses with dram_wdata = 0xCD; rdata = 0x00CD.
REQ-041 IRAM_WP=1; write 0x5555 to 0x0010 -> iram_we stays 0 and err = 1 for one cycle; a subsequent read returns the prior contents.
REQ-042 RD_LAT=3; read 0x8000 -> ready low for 4 cycles; rvalid 4 cycles after acceptance; upper bits of rdata are 0.
REQ-043 Read accepted, then rst1_n low for one cycle in WAIT -> rvalid never asserts; ready = 1 the cycle after release.
REQ-044 req held high with we=0 continuously -> exactly one rvalid per RD_LAT+2 cycles; no write strobes ever.

Source files
------------

// File: rtl/mem_select_ctrl.sv
// mem_select_ctrl
//   Routes CPU read/write requests to an internal RAM (IRAM, low address
//   window) or an external byte-wide RAM (DRAM, everything above). Writes
//   complete in the acceptance cycle. Reads wait RD_LAT cycles for the
//   selected memory and then return the data with a one-cycle rvalid pulse.
//
// Ports
//   clk1, rst1_n      single clock, synchronous active-low reset
//   req, we           CPU request and direction (1 = write)
//   addr, wdata       CPU address and write data
//   ready             high when a request can be accepted (IDLE only)
//   rvalid, rdata     read response pulse and registered read data
//   err               one-cycle pulse after a write to protected IRAM
//   iram_*            IRAM strobe/address/data (2^IRAM_AW words)
//   dram_*            DRAM strobe/address/data (DRAM_W bits wide)
//
// State table
//   state  | meaning
//   IDLE   | ready; writes complete here, reads are latched and launched
//   WAIT   | counting down the memory read latency
//   RESP   | read data registered, rvalid high for this one cycle

module mem_select_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DRAM_W  = 8,
  parameter int IRAM_AW = 10,
  parameter int RD_LAT  = 1,
  parameter int IRAM_WP = 0
) (
  input  logic               clk1,
  input  logic               rst1_n,
  input  logic               req,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic               ready,
  output logic               rvalid,
  output logic [DATA_W-1:0]  rdata,
  output logic               err,
  output logic               iram_we,
  output logic [IRAM_AW-1:0] iram_addr,
  output logic [DATA_W-1:0]  iram_wdata,
  input  logic [DATA_W-1:0]  iram_rdata,
  output logic               dram_we,
  output logic [ADDR_W-1:0]  dram_addr,
  output logic [DRAM_W-1:0]  dram_wdata,
  input  logic [DRAM_W-1:0]  dram_rdata
);

  // RD_LAT is at most 4, so the latency down-counter only needs 0..3.
  localparam int             CNT_W    = 2;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);
  localparam bit             WP       = (IRAM_WP != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   lat_cnt;
  logic [CNT_W-1:0]   lat_nxt;
  logic               sel_q;
  logic               sel_nxt;
  logic               sel_d;
  logic [DATA_W-1:0]  rdata_nxt;
  logic               err_nxt;

  // Any address bit above the IRAM window selects DRAM.
  assign sel_d = |addr[ADDR_W-1:IRAM_AW];

  assign iram_addr  = addr[IRAM_AW-1:0];
  assign iram_wdata = wdata;
  assign dram_addr  = addr;
  assign dram_wdata = wdata[DRAM_W-1:0];

  always_ff @(posedge clk1) begin
    if (!rst1_n) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      sel_q   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      sel_q   <= sel_nxt;
      rdata   <= rdata_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    sel_nxt   = sel_q;
    rdata_nxt = rdata;
    err_nxt   = 1'b0;
    ready     = 1'b0;
    rvalid    = 1'b0;
    iram_we   = 1'b0;
    dram_we   = 1'b0;

    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (we) begin
            // Strobes are gated by reset so a write held across reset
            // never reaches the memories.
            if (sel_d) begin
              dram_we = rst1_n;
            end else if (WP) begin
              err_nxt = 1'b1;
            end else begin
              iram_we = rst1_n;
            end
          end else begin
            state_nxt = S_WAIT;
            lat_nxt   = LAT_LOAD;
            sel_nxt   = sel_d;
          end
        end
      end

      S_WAIT: begin
        if (lat_cnt == '0) begin
          // Memory data is valid now, RD_LAT cycles after acceptance.
          state_nxt = S_RESP;
          rdata_nxt = sel_q ? DATA_W'(dram_rdata) : iram_rdata;
        end else begin
          lat_nxt = lat_cnt - 1'b1;
        end
      end

      S_RESP: begin
        rvalid    = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_select_ctrl.sv
module tb_mem_select_ctrl;

  logic clk1;
  logic rst1_n;

  // Instance A: default parameters
  logic        req0, we0;
  logic [15:0] addr0, wdata0;
  logic        ready0, rvalid0, err0;
  logic [15:0] rdata0;
  logic        iram_we0, dram_we0;
  logic [9:0]  iram_addr0;
  logic [15:0] iram_wdata0, iram_rdata0;
  logic [15:0] dram_addr0;
  logic [7:0]  dram_wdata0, dram_rdata0;

  // Instance B: RD_LAT=3, IRAM write-protected
  logic        req1, we1;
  logic [15:0] addr1, wdata1;
  logic        ready1, rvalid1, err1;
  logic [15:0] rdata1;
  logic        iram_we1, dram_we1;
  logic [9:0]  iram_addr1;
  logic [15:0] iram_wdata1, iram_rdata1;
  logic [15:0] dram_addr1;
  logic [7:0]  dram_wdata1, dram_rdata1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_select_ctrl u_a (
    .clk1(clk1), .rst1_n(rst1_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .rvalid(rvalid0), .rdata(rdata0), .err(err0),
    .iram_we(iram_we0), .iram_addr(iram_addr0), .iram_wdata(iram_wdata0), .iram_rdata(iram_rdata0),
    .dram_we(dram_we0), .dram_addr(dram_addr0), .dram_wdata(dram_wdata0), .dram_rdata(dram_rdata0)
  );

  mem_select_ctrl #(.RD_LAT(3), .IRAM_WP(1)) u_b (
    .clk1(clk1), .rst1_n(rst1_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .err(err1),
    .iram_we(iram_we1), .iram_addr(iram_addr1), .iram_wdata(iram_wdata1), .iram_rdata(iram_rdata1),
    .dram_we(dram_we1), .dram_addr(dram_addr1), .dram_wdata(dram_wdata1), .dram_rdata(dram_rdata1)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  // Memory models: A has one-cycle read latency, B three.
  logic [15:0] imem0 [0:1023];
  logic [7:0]  dmem0 [0:65535];
  logic [15:0] imem1 [0:1023];
  logic [7:0]  dmem1 [0:65535];
  logic [15:0] ip1 [0:2];
  logic [7:0]  dp1 [0:2];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      imem0[i] <= 16'h0;
      imem1[i] <= 16'h0;
    end
    for (int i = 0; i < 65536; i++) begin
      dmem0[i] <= 8'h0;
      dmem1[i] <= 8'h0;
    end
    imem1[16]    <= 16'h2222;
    dmem1[32768] <= 8'hA5;
  end

  always @(posedge clk1) begin
    if (iram_we0) imem0[iram_addr0] <= iram_wdata0;
    if (dram_we0) dmem0[dram_addr0] <= dram_wdata0;
    iram_rdata0 <= imem0[iram_addr0];
    dram_rdata0 <= dmem0[dram_addr0];
  end

  always @(posedge clk1) begin
    if (iram_we1) imem1[iram_addr1] <= iram_wdata1;
    if (dram_we1) dmem1[dram_addr1] <= dram_wdata1;
    ip1[0] <= imem1[iram_addr1];
    ip1[1] <= ip1[0];
    ip1[2] <= ip1[1];
    dp1[0] <= dmem1[dram_addr1];
    dp1[1] <= dp1[0];
    dp1[2] <= dp1[1];
  end
  assign iram_rdata1 = ip1[2];
  assign dram_rdata1 = dp1[2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Scoreboard for instance A reads
  typedef struct {
    logic [15:0] data;
    int          acc_cyc;
  } exp_t;
  exp_t sb_q[$];

  always @(negedge clk1) begin
    exp_t e;
    check("a_both_we", {31'd0, iram_we0 & dram_we0}, 32'd0);
    if (!(req0 && ready0 && we0 && rst1_n))
      check("a_stray_we", {31'd0, iram_we0 | dram_we0}, 32'd0);
    check("a_err", {31'd0, err0}, 32'd0);
    if (rvalid0) begin
      if (sb_q.size() == 0) begin
        check("a_rvalid_unexpected", {31'd0, rvalid0}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("a_rdata", {16'd0, rdata0}, {16'd0, e.data});
        check("a_rd_latency", cyc - e.acc_cyc, 32'd2);
      end
    end
  end

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    bit          eiwe;
    bit          edwe;
    logic [15:0] erd;
  } vec_t;

  vec_t tbl [9];

  task automatic a_access(input vec_t v);
    bit got;
    got = 1'b0;
    @(posedge clk1); #1;
    req0 = 1'b1; we0 = v.w; addr0 = v.a; wdata0 = v.d;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk1);
      if (ready0) got = 1'b1;
    end
    check("a_accept_timeout", {31'd0, got}, 32'd1);
    if (got) begin
      check("a_iram_we", {31'd0, iram_we0}, {31'd0, v.eiwe});
      check("a_dram_we", {31'd0, dram_we0}, {31'd0, v.edwe});
      if (v.edwe) check("a_dram_wdata", {24'd0, dram_wdata0}, {24'd0, v.d[7:0]});
      if (!v.w) sb_q.push_back('{v.erd, cyc});
    end
    @(posedge clk1); #1;
    req0 = 1'b0;
  endtask

  task automatic b_write(input logic [15:0] a, input logic [15:0] d,
                         input bit eiwe, input bit edwe, input bit eerr);
    @(posedge clk1); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d;
    @(negedge clk1);
    check("b_w_ready", {31'd0, ready1}, 32'd1);
    check("b_w_iram_we", {31'd0, iram_we1}, {31'd0, eiwe});
    check("b_w_dram_we", {31'd0, dram_we1}, {31'd0, edwe});
    if (edwe) check("b_w_dram_wdata", {24'd0, dram_wdata1}, {24'd0, d[7:0]});
    check("b_w_err_early", {31'd0, err1}, 32'd0);
    @(posedge clk1); #1;
    req1 = 1'b0; we1 = 1'b0;
    @(negedge clk1);
    check("b_w_err_pulse", {31'd0, err1}, {31'd0, eerr});
    @(negedge clk1);
    check("b_w_err_clear", {31'd0, err1}, 32'd0);
  endtask

  task automatic b_read(input logic [15:0] a, input logic [15:0] exp);
    int rv_k, rv_n, low_n;
    logic [15:0] rd;
    rv_k = 0; rv_n = 0; low_n = 0; rd = 16'h0;
    @(posedge clk1); #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = a;
    @(negedge clk1);
    check("b_r_accept", {31'd0, ready1}, 32'd1);
    @(posedge clk1); #1;
    req1 = 1'b0; addr1 = 16'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk1);
      if (!ready1) low_n++;
      if (rvalid1) begin
        rv_n++;
        rv_k = k;
        rd = rdata1;
      end
    end
    check("b_r_ready_low_cycles", low_n, 32'd4);
    check("b_r_rvalid_count", rv_n, 32'd1);
    check("b_r_latency", rv_k, 32'd4);
    check("b_r_rdata", {16'd0, rd}, {16'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int acc;
    tbl[0] = '{1'b1, 16'h03FF, 16'h1234, 1'b1, 1'b0, 16'h0000};
    tbl[1] = '{1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b0, 16'h1234};
    tbl[2] = '{1'b1, 16'h0400, 16'hABCD, 1'b0, 1'b1, 16'h0000};
    tbl[3] = '{1'b0, 16'h0400, 16'h0000, 1'b0, 1'b0, 16'h00CD};
    tbl[4] = '{1'b1, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
    tbl[5] = '{1'b1, 16'hFFFF, 16'h1277, 1'b0, 1'b1, 16'h0000};
    tbl[6] = '{1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0077};
    tbl[7] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'hBEEF};
    tbl[8] = '{1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b0, 16'h1234};

    rst1_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 16'h0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check("rst_a_ready", {31'd0, ready0}, 32'd1);
    check("rst_a_rvalid", {31'd0, rvalid0}, 32'd0);
    check("rst_a_rdata", {16'd0, rdata0}, 32'd0);
    check("rst_b_ready", {31'd0, ready1}, 32'd1);
    check("rst_b_err", {31'd0, err1}, 32'd0);
    check("rst_b_rdata", {16'd0, rdata1}, 32'd0);
    @(posedge clk1); #1;
    rst1_n = 1'b1;

    for (int i = 0; i < 9; i++) a_access(tbl[i]);

    repeat (4) @(posedge clk1);
    @(negedge clk1);
    check("a_sb_drain", sb_q.size(), 32'd0);
    check("a_rdata_hold", {16'd0, rdata0}, 32'h1234);

    // Continuous read requests: one acceptance every RD_LAT+2 = 3 cycles.
    @(posedge clk1); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0400;
    acc = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk1);
      if (ready0) begin
        acc++;
        sb_q.push_back('{16'h00CD, cyc});
      end
    end
    @(posedge clk1); #1;
    req0 = 1'b0;
    check("a_b2b_accepts", acc, 32'd4);
    repeat (4) @(negedge clk1);
    check("a_b2b_drain", sb_q.size(), 32'd0);

    // Reset during WAIT aborts the read; a write held through reset is dropped.
    @(posedge clk1); #1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h03FF;
    @(negedge clk1);
    check("a_rstwait_accept", {31'd0, ready0}, 32'd1);
    @(posedge clk1); #1;
    rst1_n = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0400; wdata0 = 16'h9999;
    @(negedge clk1);
    check("a_rstwait_dram_we", {31'd0, dram_we0}, 32'd0);
    @(posedge clk1); #1;
    rst1_n = 1'b1; req0 = 1'b0; we0 = 1'b0;
    @(negedge clk1);
    check("a_ready_after_rst", {31'd0, ready0}, 32'd1);
    repeat (5) @(negedge clk1);

    @(posedge clk1); #1;
    rst1_n = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0400; wdata0 = 16'h9999;
    @(negedge clk1);
    check("a_rstidle_ready", {31'd0, ready0}, 32'd1);
    check("a_rstidle_dram_we", {31'd0, dram_we0}, 32'd0);
    @(posedge clk1); #1;
    rst1_n = 1'b1; req0 = 1'b0; we0 = 1'b0;
    a_access('{1'b0, 16'h0400, 16'h0000, 1'b0, 1'b0, 16'h00CD});
    repeat (4) @(negedge clk1);
    check("a_final_drain", sb_q.size(), 32'd0);

    // Instance B: protected IRAM and three-cycle latency
    b_write(16'h0010, 16'h5555, 1'b0, 1'b0, 1'b1);
    b_read(16'h0010, 16'h2222);
    b_read(16'h8000, 16'h00A5);
    b_write(16'h8001, 16'h1234, 1'b0, 1'b1, 1'b0);
    b_read(16'h8001, 16'h0034);
    b_read(16'h03FF, 16'h0000);

    repeat (2) @(posedge clk1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
